// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue.
//
// Fetches sequential instruction words from memory, keeping at most one request in
// flight, and buffers the responses in a DEPTH-entry FIFO for the decode stage.
// A redirect flushes the queue, restarts fetching at the new (word-aligned) address,
// and marks any in-flight response so that it is dropped when it arrives.
//
// Optional feature macro: PREFETCH_PERF_EN enables the two performance counters;
// without it perf_fetched/perf_flushed are tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   redirect       flush queue and restart fetch at redirect_pc
//   redirect_pc    new fetch address (low two bits ignored)
//   stall          decode not accepting the head instruction this cycle
//   mem_req        fetch request valid (accepted in the cycle it is high)
//   mem_addr       fetch word address
//   mem_rvalid     fetch response valid
//   mem_rdata      fetch response word
//   inst, inst_pc  head instruction and its address (nop / fetch_pc when empty)
//   inst_status    2'b10 head valid, 2'b01 flushing, 2'b00 empty
//   perf_fetched   responses pushed into the queue
//   perf_flushed   redirects taken
module inst_prefetch_queue #(
    parameter logic [31:0] START_ADDR = 32'h1000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_status,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_addr_q;
    logic          outstanding_q;
    logic          discard_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [63:0]   mem_q [DEPTH];

    logic push;
    logic pop;
    logic resp;
    logic head_valid;
    logic unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign head_valid = (count_q != '0);
    // A response is only meaningful while a request is outstanding.
    assign resp = mem_rvalid && outstanding_q;
    assign push = resp && !discard_q && !redirect;
    assign pop  = head_valid && !stall && !redirect;

    // The pending slot is reserved at issue time, so a push can never find the queue full.
    assign mem_req  = !rst && !outstanding_q && !redirect && (count_q < CW'(DEPTH));
    assign mem_addr = fetch_pc_q;

    always_comb begin
        inst        = 32'h0;
        inst_pc     = fetch_pc_q;
        inst_status = 2'b00;
        if (!rst) begin
            if (head_valid) begin
                inst        = mem_q[rd_ptr_q][63:32];
                inst_pc     = mem_q[rd_ptr_q][31:0];
                inst_status = 2'b10;
            end else if (discard_q) begin
                inst_status = 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= START_ADDR;
            req_addr_q    <= START_ADDR;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else if (redirect) begin
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            if (resp) begin
                // The in-flight response lands now and is dropped immediately.
                outstanding_q <= 1'b0;
                discard_q     <= 1'b0;
            end else if (outstanding_q) begin
                discard_q <= 1'b1;
            end
        end else begin
            if (resp) begin
                outstanding_q <= 1'b0;
                discard_q     <= 1'b0;
            end
            if (mem_req) begin
                outstanding_q <= 1'b1;
                req_addr_q    <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage needs no reset; count and pointers qualify its contents.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {mem_rdata, req_addr_q};
        end
    end

`ifdef PREFETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (push) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (redirect) begin
                perf_flushed_q <= perf_flushed_q + 32'd1;
            end
        end
    end

    assign perf_fetched = rst ? 32'h0 : perf_fetched_q;
    assign perf_flushed = rst ? 32'h0 : perf_flushed_q;
`else
    assign perf_fetched = 32'h0;
    assign perf_flushed = 32'h0;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: a latency-configurable memory responder,
// a reference model of the queue, and a scoreboard of expected {inst, pc} entries that
// is pushed when a response should be accepted and popped when decode consumes the head.
module tb_inst_prefetch_queue;

    localparam int unsigned DEPTH = 4;
`ifdef PREFETCH_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_status;
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;

    inst_prefetch_queue #(
        .START_ADDR(32'h1000),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_status (inst_status),
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Memory responder state.
    int          lat = 1;
    bit          mem_busy = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_a = '0;

    // Reference model and scoreboard.
    logic [31:0] m_pc = 32'h1000;
    logic [31:0] m_req_addr = '0;
    bit          m_out = 1'b0;
    bit          m_disc = 1'b0;
    logic [31:0] m_fetched = '0;
    logic [31:0] m_flushed = '0;
    logic [63:0] exp_q[$];
    logic [31:0] issued[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, update model at edge.
    task automatic step(input bit r, input bit redir, input logic [31:0] rpc, input bit stl,
                        input bit stray);
        bit          due;
        bit          rv;
        bit          exp_req;
        bit          req_seen;
        logic [31:0] data;
        logic [63:0] head;
        due = mem_busy && (mem_wait == 1);
        rv  = due || stray;
        data = due ? data_of(mem_a) : (stray ? 32'hBAD0_0000 : 32'h0);
        rst         = r;
        redirect    = redir;
        redirect_pc = rpc;
        stall       = stl;
        mem_rvalid  = rv;
        mem_rdata   = data;
        #1;
        exp_req = !r && !m_out && !redir && (exp_q.size() < DEPTH);
        if (r) begin
            check("rst_mem_req", {31'b0, mem_req}, 32'h0);
            check("rst_inst", inst, 32'h0);
            check("rst_status", {30'b0, inst_status}, 32'h0);
            check("rst_perf_fetched", perf_fetched, 32'h0);
            check("rst_perf_flushed", perf_flushed, 32'h0);
        end else begin
            check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
            if (mem_req && exp_req) check("mem_addr", mem_addr, m_pc);
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                check("status_valid", {30'b0, inst_status}, 32'h2);
                check("inst", inst, head[63:32]);
                check("inst_pc", inst_pc, head[31:0]);
            end else begin
                check("status_empty", {30'b0, inst_status}, m_disc ? 32'h1 : 32'h0);
                check("inst_nop", inst, 32'h0);
                check("inst_pc_empty", inst_pc, m_pc);
            end
            check("perf_fetched", perf_fetched, PerfEn ? m_fetched : 32'h0);
            check("perf_flushed", perf_flushed, PerfEn ? m_flushed : 32'h0);
        end
        req_seen = mem_req;
        if (req_seen) issued.push_back(mem_addr);
        // Reference model update for this edge.
        if (r) begin
            m_pc = 32'h1000; m_out = 0; m_disc = 0; m_fetched = '0; m_flushed = '0;
            exp_q.delete();
        end else if (redir) begin
            exp_q.delete();
            if (m_out && rv) begin
                m_out = 0; m_disc = 0;
            end else if (m_out) begin
                m_disc = 1;
            end
            m_pc = {rpc[31:2], 2'b00};
            m_flushed++;
        end else begin
            if (exp_q.size() != 0 && !stl) void'(exp_q.pop_front());
            if (rv && m_out) begin
                m_out = 0;
                if (m_disc) m_disc = 0;
                else begin
                    exp_q.push_back({data, m_req_addr});
                    m_fetched++;
                end
            end
            if (exp_req) begin
                m_out = 1; m_req_addr = m_pc; m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        if (due) mem_busy = 0;
        else if (mem_busy) mem_wait--;
        if (req_seen) begin
            mem_busy = 1; mem_wait = lat; mem_a = issued[issued.size()-1];
        end
    endtask

    task automatic run(input int n, input bit stl);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, stl, 0);
    endtask

    // Quiet inputs mid-cycle so the combinational outputs can be inspected directly.
    task automatic settle_idle();
        rst = 0; redirect = 0; stall = 0; mem_rvalid = 0; mem_rdata = '0;
        #1;
    endtask

    initial begin
        rst = 1; redirect = 0; redirect_pc = '0; stall = 0; mem_rvalid = 0; mem_rdata = '0;

        // Reset, then sequential fetch at latency 1.
        lat = 1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        issued.delete();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        settle_idle();
        check("first_valid_status", {30'b0, inst_status}, 32'h2);
        check("first_valid_pc", inst_pc, 32'h1000);
        run(6, 0);
        check("n_issued_seq", {31'b0, issued.size() >= 3}, 32'h1);
        if (issued.size() >= 3) begin
            check("seq_addr0", issued[0], 32'h1000);
            check("seq_addr1", issued[1], 32'h1004);
            check("seq_addr2", issued[2], 32'h1008);
        end

        // Stall held: queue fills to DEPTH then fetching stops; release drains in order.
        step(1, 0, 0, 0, 0);
        issued.delete();
        run(14, 1);
        check("fill_issued", issued.size(), DEPTH);
        settle_idle();
        check("fill_head_pc", inst_pc, 32'h1000);
        run(6, 0);

        // Full queue: redirect + pop + stray rvalid in one cycle.
        step(1, 0, 0, 0, 0);
        run(14, 1);
        step(0, 1, 32'h3000, 0, 1);
        settle_idle();
        check("full_redir_status", {30'b0, inst_status}, 32'h0);
        check("full_redir_req", {31'b0, mem_req}, 32'h1);
        check("full_redir_addr", mem_addr, 32'h3000);
        run(6, 0);

        // Redirect while 0x1008 is outstanding at latency 3.
        lat = 3;
        step(1, 0, 0, 0, 0);
        issued.delete();
        for (int i = 0; i < 60 && !(mem_busy && mem_a == 32'h1008 && mem_wait == 3); i++)
            step(0, 0, 0, 0, 0);
        check("found_1008", {31'b0, mem_busy && mem_a == 32'h1008}, 32'h1);
        step(0, 1, 32'h2002, 0, 0);
        settle_idle();
        check("flushing_status", {30'b0, inst_status}, 32'h1);
        issued.delete();
        run(16, 0);
        check("n_issued_redir", {31'b0, issued.size() >= 1}, 32'h1);
        if (issued.size() >= 1) check("redir_addr", issued[0], 32'h2000);

        // Redirect coincident with the response.
        lat = 2;
        for (int i = 0; i < 20 && !(mem_busy && mem_wait == 1); i++) step(0, 0, 0, 0, 0);
        check("found_due", {31'b0, mem_busy && mem_wait == 1}, 32'h1);
        step(0, 1, 32'h4000, 0, 0);
        settle_idle();
        check("coinc_req", {31'b0, mem_req}, 32'h1);
        check("coinc_addr", mem_addr, 32'h4000);
        check("coinc_status", {30'b0, inst_status}, 32'h0);
        run(8, 0);

        // Address wrap past 0xFFFFFFFC.
        lat = 1;
        for (int i = 0; i < 10 && mem_busy; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 32'hFFFF_FFFE, 0, 0);
        for (int i = 0; i < 10 && mem_busy; i++) step(0, 0, 0, 0, 0);
        issued.delete();
        run(6, 0);
        check("n_issued_wrap", {31'b0, issued.size() >= 2}, 32'h1);
        if (issued.size() >= 2) begin
            check("wrap_addr0", issued[0], 32'hFFFF_FFFC);
            check("wrap_addr1", issued[1], 32'h0000_0000);
        end

        // Reset mid-request; the abandoned response lands during reset.
        lat = 3;
        for (int i = 0; i < 20 && !mem_busy; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        run(14, 1);
        step(0, 0, 0, 1, 1);   // stray rvalid with nothing outstanding
        run(10, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit rd;
            lat = int'($urandom_range(1, 3));
            rd = ($urandom_range(0, 15) == 0);
            step(0, rd, $urandom, ($urandom_range(0, 2) == 0), 0);
        end
        run(10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
